sram512x8_rr_arbiter: RTL and testbench
=======================================

SRAM512X8_RR_ARBITER -- requirements
Module: sram512x8_rr_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero-fill all 512 words after reset; 0 = skip the fill.
REQ-002 SHALL have port CLK, input, 1: the single clock, all flops rising-edge.
REQ-003 SHALL have port RSTN, input, 1: asynchronous active-low reset.
REQ-004 SHALL have, per requester i in {0,1}, port REQi_VALID, input, 1: access request.
REQ-005 SHALL have port REQi_READY, output, 1: request accepted this cycle.
REQ-006 SHALL have port REQi_WE, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port REQi_A, input, 9: word address.
REQ-008 SHALL have port REQi_D, input, 8: write data.
REQ-009 SHALL have port REQi_BM, input, 8: active-high bit write mask.
REQ-010 SHALL have port RSPi_VALID, output, 1: read data valid.
REQ-011 SHALL have port RSPi_Q, output, 8: read data.
REQ-012 SHALL have SRAM-side outputs SRAM_CEN (1), SRAM_GWEN (1), SRAM_WEN (8), SRAM_A (9), SRAM_D (8), all active-low enables, and input SRAM_Q (8).
REQ-013 SHALL have port CLEAR_DONE, output, 1: high once the arbiter is in service.

Function
REQ-014 SHALL implement FSM states CLEAR and SERVE; reset enters CLEAR if CLEAR_ON_RESET=1, else SERVE.
REQ-015 In CLEAR, SHALL issue one write per cycle to addresses 0..511 ascending: CEN=0, GWEN=0, WEN=8'h00, D=8'h00; both READY low.
REQ-016 After the address-511 write is issued, SHALL enter SERVE on the next edge; SERVE is terminal until reset.
REQ-017 CLEAR_DONE SHALL equal (state==SERVE).
REQ-018 In SERVE, SHALL grant at most one requester per cycle; REQi_READY = REQi_VALID & grant_i, combinational from VALID.
REQ-019 Round-robin: a sole valid requester is granted; when both are valid, the requester not granted most recently wins; priority pointer resets to requester 0.
REQ-020 Priority pointer SHALL update only on an accepted transfer (VALID & READY).
REQ-021 Requesters SHALL hold VALID, WE, A, D, BM stable until READY; the arbiter SHALL NOT depend on a VALID withdrawal.
REQ-022 SRAM_* outputs SHALL be registered: the transfer accepted at edge N drives the SRAM from edge N, so the SRAM samples it at edge N+1.
REQ-023 A write SHALL drive GWEN=0, WEN=~BM, D=REQ_D; a write with BM=0 is issued as a write with WEN=8'hFF (no-op) and produces no response.
REQ-024 A read SHALL drive GWEN=1, WEN=8'hFF; RSPi_VALID SHALL be high for exactly the one cycle after edge N+1, with RSPi_Q = SRAM_Q passthrough.
REQ-025 RSPi_Q SHALL be don't-care while RSPi_VALID is low.
REQ-026 A cycle with no accepted transfer SHALL register CEN=1; A and D hold their previous values.
REQ-027 Throughput SHALL be one access per cycle; back-to-back accesses to the same address SHALL complete in issue order, so read-after-write returns the new data.
REQ-028 Both RSP_VALID outputs SHALL never be high in the same cycle.

Reset
REQ-029 While RSTN is low: SRAM_CEN=1, SRAM_GWEN=1, SRAM_WEN=8'hFF, SRAM_A=0, SRAM_D=0, RSP*_VALID=0, REQ*_READY=0, CLEAR_DONE=0, clear counter=0, pointer=0.
REQ-030 Reset asserted mid-clear or mid-read SHALL discard all in-flight state; after release the clear restarts at address 0 and no stale RSP_VALID appears.

Structure
REQ-031 SHALL place address width 9, data width 8, depth 512 and the FSM state enum in a shared package sram512x8_pkg.
REQ-032 The two-input round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: valid[1:0], advance; outputs: grant[1:0]).

Verification
REQ-033 Bench SHALL cover: CLEAR_ON_RESET=1, reset released -> 512 writes at A=0..511 with D=0, WEN=8'h00; CLEAR_DONE rises the cycle after A=511 is issued; READY low throughout.
REQ-034 Bench SHALL cover: REQ0 write A=9'h1A5, D=8'h3C, BM=8'hFF; then REQ1 read A=9'h1A5 -> RSP1_VALID one cycle after the SRAM edge, RSP1_Q=8'h3C.
REQ-035 Bench SHALL cover: both VALID held high for 6 reads -> grants alternate 0,1,0,1,0,1; one RSP per cycle from the 3rd cycle onward.
REQ-036 Bench SHALL cover: masked write BM=8'h0F, D=8'hAB over 8'h55 -> readback 8'h5B.
REQ-037 Bench SHALL cover: RSTN pulsed low at clear address 200 -> restart at 0; full 512-write sweep; no RSP_VALID.
REQ-038 Bench SHALL cover: CLEAR_ON_RESET=0 -> CLEAR_DONE=1 in the first cycle after reset; an immediate REQ0 read is accepted the same cycle.

Source files
------------

// File: rtl/sram512x8_pkg.sv
// Shared definitions for the 512x8 SRAM round-robin arbiter.
// Holds the memory geometry, the FSM state encoding and a small helper
// that turns an active-high bit mask into the SRAM's active-low WEN.
package sram512x8_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 512;

  // Clear counter runs one past the last address so the final clear
  // write is on the SRAM pins for a full cycle before SERVE is entered.
  localparam logic [ADDR_W:0] CLR_END = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  function automatic logic [DATA_W-1:0] wen_from_mask(input logic [DATA_W-1:0] bm);
    return ~bm;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant logic.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset (priority returns to input 0)
//   valid   - request vector
//   advance - high when the granted request is actually accepted
//   grant   - one-hot (or zero) combinational grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // prio_q = 0: requester 0 wins a tie; prio_q = 1: requester 1 wins.
  logic prio_q;
  logic prio_d;

  always_comb begin
    grant[0] = valid[0] & (~valid[1] | ~prio_q);
    grant[1] = valid[1] & (~valid[0] |  prio_q);
  end

  // The winner of an accepted transfer hands priority to the other side.
  always_comb begin
    prio_d = prio_q;
    if (advance) begin
      if (grant[0])      prio_d = 1'b1;
      else if (grant[1]) prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/sram512x8_rr_arbiter.sv
// Two-port round-robin front end for a single-port 512x8 SRAM macro.
// After reset it optionally zero-fills the array (CLEAR), then serves one
// request per cycle (SERVE). All SRAM-side signals are registered; read
// data returns as a one-cycle RSPi_VALID pulse with RSPi_Q taken straight
// from SRAM_Q.
// Ports:
//   CLK, RSTN                      - clock, async active-low reset
//   REQi_VALID/READY/WE/A/D/BM     - requester i command channel
//   RSPi_VALID/Q                   - requester i read response
//   SRAM_CEN/GWEN/WEN/A/D, SRAM_Q  - SRAM macro interface (active-low enables)
//   CLEAR_DONE                     - arbiter is in service
module sram512x8_rr_arbiter
  import sram512x8_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic              REQ0_WE,
  input  logic [ADDR_W-1:0] REQ0_A,
  input  logic [DATA_W-1:0] REQ0_D,
  input  logic [DATA_W-1:0] REQ0_BM,
  output logic              RSP0_VALID,
  output logic [DATA_W-1:0] RSP0_Q,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic              REQ1_WE,
  input  logic [ADDR_W-1:0] REQ1_A,
  input  logic [DATA_W-1:0] REQ1_D,
  input  logic [DATA_W-1:0] REQ1_BM,
  output logic              RSP1_VALID,
  output logic [DATA_W-1:0] RSP1_Q,
  output logic              SRAM_CEN,
  output logic              SRAM_GWEN,
  output logic [DATA_W-1:0] SRAM_WEN,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_D,
  input  logic [DATA_W-1:0] SRAM_Q,
  output logic              CLEAR_DONE
);

  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_q, clr_d;
  logic              cen_q, cen_d;
  logic              gwen_q, gwen_d;
  logic [DATA_W-1:0] wen_q, wen_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [1:0]        rd_pend_q, rd_pend_d;   // read on the SRAM pins, per requester
  logic [1:0]        rsp_vld_q, rsp_vld_d;

  logic              serve;
  logic [1:0]        valid;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_d;
  logic [DATA_W-1:0] sel_bm;

  assign valid = {REQ1_VALID, REQ0_VALID};

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst_n   (RSTN),
    .valid   (valid),
    .advance (accept),
    .grant   (grant)
  );

  // RSTN gates READY and CLEAR_DONE so both are low for the whole reset
  // window, including the CLEAR_ON_RESET=0 case where state resets to SERVE.
  always_comb begin
    serve  = (state_q == ST_SERVE);
    ready  = valid & grant & {2{serve & RSTN}};
    accept = |ready;
    sel_we = ready[1] ? REQ1_WE : REQ0_WE;
    sel_a  = ready[1] ? REQ1_A  : REQ0_A;
    sel_d  = ready[1] ? REQ1_D  : REQ0_D;
    sel_bm = ready[1] ? REQ1_BM : REQ0_BM;
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    cen_d     = 1'b1;
    gwen_d    = 1'b1;
    wen_d     = '1;
    a_d       = a_q;
    d_d       = d_q;
    rd_pend_d = 2'b00;
    rsp_vld_d = rd_pend_q;

    if (!serve) begin
      if (clr_q != CLR_END) begin
        cen_d  = 1'b0;
        gwen_d = 1'b0;
        wen_d  = '0;
        a_d    = clr_q[ADDR_W-1:0];
        d_d    = '0;
        clr_d  = clr_q + 1'b1;
      end else begin
        state_d = ST_SERVE;
      end
    end else if (accept) begin
      cen_d = 1'b0;
      a_d   = sel_a;
      if (sel_we) begin
        // An all-zero mask yields WEN=FF: the cycle is spent, nothing changes.
        gwen_d = 1'b0;
        wen_d  = wen_from_mask(sel_bm);
        d_d    = sel_d;
      end else begin
        rd_pend_d = ready;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= RST_STATE;
      clr_q     <= '0;
      cen_q     <= 1'b1;
      gwen_q    <= 1'b1;
      wen_q     <= '1;
      a_q       <= '0;
      d_q       <= '0;
      rd_pend_q <= 2'b00;
      rsp_vld_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      cen_q     <= cen_d;
      gwen_q    <= gwen_d;
      wen_q     <= wen_d;
      a_q       <= a_d;
      d_q       <= d_d;
      rd_pend_q <= rd_pend_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  assign REQ0_READY = ready[0];
  assign REQ1_READY = ready[1];
  assign RSP0_VALID = rsp_vld_q[0];
  assign RSP1_VALID = rsp_vld_q[1];
  assign RSP0_Q     = SRAM_Q;
  assign RSP1_Q     = SRAM_Q;
  assign SRAM_CEN   = cen_q;
  assign SRAM_GWEN  = gwen_q;
  assign SRAM_WEN   = wen_q;
  assign SRAM_A     = a_q;
  assign SRAM_D     = d_q;
  assign CLEAR_DONE = serve & RSTN;

endmodule

// File: tb/tb_sram512x8_rr_arbiter.sv
// Bench for sram512x8_rr_arbiter: two instances (with and without the
// reset-time clear), behavioural SRAM macros, queue-fed requesters and a
// per-cycle reference model of grants, SRAM pins and read responses.
module tb_sram512x8_rr_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instance with clear ----------------
  logic       rstn = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_we = '0;
  logic [8:0] req_a [2];
  logic [7:0] req_d [2];
  logic [7:0] req_bm [2];
  wire  [1:0] ready;
  wire  [1:0] rsp_valid;
  wire  [7:0] rsp_q0, rsp_q1;
  wire        sram_cen, sram_gwen, clear_done;
  wire  [7:0] sram_wen, sram_d;
  wire  [8:0] sram_a;
  logic [7:0] sram_q = '0;
  logic [7:0] mem [512];

  sram512x8_rr_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
    .CLK(CLK), .RSTN(rstn),
    .REQ0_VALID(req_valid[0]), .REQ0_READY(ready[0]), .REQ0_WE(req_we[0]),
    .REQ0_A(req_a[0]), .REQ0_D(req_d[0]), .REQ0_BM(req_bm[0]),
    .RSP0_VALID(rsp_valid[0]), .RSP0_Q(rsp_q0),
    .REQ1_VALID(req_valid[1]), .REQ1_READY(ready[1]), .REQ1_WE(req_we[1]),
    .REQ1_A(req_a[1]), .REQ1_D(req_d[1]), .REQ1_BM(req_bm[1]),
    .RSP1_VALID(rsp_valid[1]), .RSP1_Q(rsp_q1),
    .SRAM_CEN(sram_cen), .SRAM_GWEN(sram_gwen), .SRAM_WEN(sram_wen),
    .SRAM_A(sram_a), .SRAM_D(sram_d), .SRAM_Q(sram_q),
    .CLEAR_DONE(clear_done)
  );

  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  // ---------------- instance without clear ----------------
  logic       b_rstn = 1'b0;
  logic       b_valid = 1'b0;
  logic       b_we = 1'b0;
  logic [8:0] b_a = '0;
  logic [7:0] b_zero8 = '0;
  logic [8:0] b_zero9 = '0;
  logic       b_zero1 = 1'b0;
  wire        b_ready0, b_ready1, b_rsp0_valid, b_rsp1_valid, b_done;
  wire  [7:0] b_rsp0_q, b_rsp1_q, b_wen, b_d;
  wire        b_cen, b_gwen;
  wire  [8:0] b_sa;
  logic [7:0] b_q = '0;
  logic [7:0] mem2 [512];

  sram512x8_rr_arbiter #(.CLEAR_ON_RESET(1'b0)) dut0 (
    .CLK(CLK), .RSTN(b_rstn),
    .REQ0_VALID(b_valid), .REQ0_READY(b_ready0), .REQ0_WE(b_we),
    .REQ0_A(b_a), .REQ0_D(b_zero8), .REQ0_BM(b_zero8),
    .RSP0_VALID(b_rsp0_valid), .RSP0_Q(b_rsp0_q),
    .REQ1_VALID(b_zero1), .REQ1_READY(b_ready1), .REQ1_WE(b_zero1),
    .REQ1_A(b_zero9), .REQ1_D(b_zero8), .REQ1_BM(b_zero8),
    .RSP1_VALID(b_rsp1_valid), .RSP1_Q(b_rsp1_q),
    .SRAM_CEN(b_cen), .SRAM_GWEN(b_gwen), .SRAM_WEN(b_wen),
    .SRAM_A(b_sa), .SRAM_D(b_d), .SRAM_Q(b_q),
    .CLEAR_DONE(b_done)
  );

  always @(posedge CLK) begin
    if (!b_cen) begin
      if (!b_gwen) mem2[b_sa] <= (mem2[b_sa] & b_wen) | (b_d & ~b_wen);
      else         b_q <= mem2[b_sa];
    end
  end

  // ---------------- requesters ----------------
  typedef struct {bit we; logic [8:0] a; logic [7:0] d; logic [7:0] bm; bit idle;} txn_t;
  txn_t dq0[$];
  txn_t dq1[$];
  logic [1:0] acc_n = '0;

  function automatic txn_t mk(bit we, logic [8:0] a, logic [7:0] d, logic [7:0] bm, bit idle);
    txn_t t;
    t.we = we; t.a = a; t.d = d; t.bm = bm; t.idle = idle;
    return t;
  endfunction

  always @(posedge CLK) begin
    txn_t t;
    #1;
    if (acc_n[0] && dq0.size() != 0) void'(dq0.pop_front());
    if (acc_n[1] && dq1.size() != 0) void'(dq1.pop_front());
    if (dq0.size() == 0) req_valid[0] = 1'b0;
    else begin
      t = dq0[0];
      if (t.idle) begin req_valid[0] = 1'b0; t.idle = 1'b0; dq0[0] = t; end
      else begin
        req_valid[0] = 1'b1; req_we[0] = t.we; req_a[0] = t.a; req_d[0] = t.d; req_bm[0] = t.bm;
      end
    end
    if (dq1.size() == 0) req_valid[1] = 1'b0;
    else begin
      t = dq1[0];
      if (t.idle) begin req_valid[1] = 1'b0; t.idle = 1'b0; dq1[0] = t; end
      else begin
        req_valid[1] = 1'b1; req_we[1] = t.we; req_a[1] = t.a; req_d[1] = t.d; req_bm[1] = t.bm;
      end
    end
  end

  // ---------------- reference model and compare ----------------
  typedef struct {int id; logic [7:0] q; int due;} rsp_t;
  rsp_t       expq[$];
  logic [7:0] exp_mem [512];
  int         ncyc = 0;
  int         m_clr = 0;
  int         m_last = 1;      // requester granted most recently
  bit         prev_acc = 1'b0;
  logic [8:0] exp_a = '0;
  logic [7:0] exp_d = '0;
  logic       exp_gwen = 1'b1;
  logic [7:0] exp_wen = '1;
  logic [1:0] exp_rv;
  logic [7:0] lastq [2];
  int         glog[$];
  int         alog[$];
  int         rlog[$];

  always @(negedge CLK) begin
    int  id;
    bit  g0, g1;
    ncyc++;
    acc_n = 2'b00;
    if (!rstn) begin
      chk("rst_cen", sram_cen, 1'b1);
      chk("rst_gwen", sram_gwen, 1'b1);
      chk("rst_wen", sram_wen, 8'hFF);
      chk("rst_a", sram_a, 9'h000);
      chk("rst_d", sram_d, 8'h00);
      chk("rst_rsp", rsp_valid, 2'b00);
      chk("rst_ready", ready, 2'b00);
      chk("rst_done", clear_done, 1'b0);
      m_clr = 0; m_last = 1; prev_acc = 1'b0; exp_a = '0; exp_d = '0;
      expq.delete();
    end else if (m_clr <= 512) begin
      chk("clr_done", clear_done, 1'b0);
      chk("clr_ready", ready, 2'b00);
      chk("clr_rsp", rsp_valid, 2'b00);
      if (m_clr == 0) chk("clr_first_cen", sram_cen, 1'b1);
      else begin
        chk("clr_cen", sram_cen, 1'b0);
        chk("clr_gwen", sram_gwen, 1'b0);
        chk("clr_wen", sram_wen, 8'h00);
        chk("clr_d", sram_d, 8'h00);
        chk("clr_a", sram_a, m_clr - 1);
      end
      m_clr++;
      if (m_clr == 513) begin
        for (int i = 0; i < 512; i++) exp_mem[i] = 8'h00;
        exp_a = 9'd511; exp_d = 8'h00; prev_acc = 1'b0;
      end
    end else begin
      chk("srv_done", clear_done, 1'b1);
      g0 = req_valid[0] && (!req_valid[1] || m_last == 1);
      g1 = req_valid[1] && (!req_valid[0] || m_last == 0);
      chk("srv_ready", ready, {g1, g0});
      chk("pin_cen", sram_cen, !prev_acc);
      if (prev_acc) begin
        chk("pin_gwen", sram_gwen, exp_gwen);
        chk("pin_wen", sram_wen, exp_wen);
      end
      chk("pin_a", sram_a, exp_a);
      chk("pin_d", sram_d, exp_d);
      exp_rv = 2'b00;
      if (expq.size() != 0 && expq[0].due <= ncyc) exp_rv[expq[0].id] = 1'b1;
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 2'b00) begin
        id = expq[0].id;
        chk("rsp_q", (id == 1) ? rsp_q1 : rsp_q0, expq[0].q);
        lastq[id] = (id == 1) ? rsp_q1 : rsp_q0;
        rlog.push_back(ncyc);
        void'(expq.pop_front());
      end
      prev_acc = 1'b0;
      if (g0 || g1) begin
        id = g1 ? 1 : 0;
        acc_n[id] = 1'b1;
        m_last = id;
        glog.push_back(id);
        alog.push_back(ncyc);
        prev_acc = 1'b1;
        exp_a = req_a[id];
        if (req_we[id]) begin
          exp_gwen = 1'b0;
          exp_wen  = ~req_bm[id];
          exp_d    = req_d[id];
          exp_mem[req_a[id]] = (exp_mem[req_a[id]] & ~req_bm[id]) | (req_d[id] & req_bm[id]);
        end else begin
          exp_gwen = 1'b1;
          exp_wen  = 8'hFF;
          expq.push_back('{id, exp_mem[req_a[id]], ncyc + 2});
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while ((dq0.size() != 0 || dq1.size() != 0 || expq.size() != 0) && n < 4000) begin
      @(posedge CLK); #3;
      n++;
    end
    total++;
    if (n >= 4000) begin
      bad++;
      $display("FAIL %s: timeout after %0d cycles, required drain", name, n);
    end
    @(posedge CLK); #3;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]  = 8'($urandom);
      mem2[i] = 8'(i) ^ 8'h5A;
    end
    req_a[0] = '0; req_a[1] = '0; req_d[0] = '0; req_d[1] = '0; req_bm[0] = '0; req_bm[1] = '0;
    lastq[0] = '0; lastq[1] = '0;

    // Reset, with a write already pending so READY is exercised through the clear.
    dq0.push_back(mk(1'b1, 9'h1A5, 8'h3C, 8'hFF, 1'b0));
    repeat (3) @(posedge CLK);
    #2 rstn = 1'b1;
    wait_idle("clear_and_first_write");
    chk("done_after_clear", clear_done, 1'b1);

    // Read-back from the other requester.
    dq1.push_back(mk(1'b0, 9'h1A5, 8'h00, 8'h00, 1'b0));
    wait_idle("raw_read");
    chk("raw_q", lastq[1], 8'h3C);

    // Both requesters streaming reads.
    glog.delete(); alog.delete(); rlog.delete();
    for (int k = 0; k < 3; k++) begin
      dq0.push_back(mk(1'b0, 9'h1A5, 8'h00, 8'h00, 1'b0));
      dq1.push_back(mk(1'b0, 9'(k), 8'h00, 8'h00, 1'b0));
    end
    wait_idle("alt_reads");
    chk("alt_count", glog.size(), 6);
    chk("rsp_count", rlog.size(), 6);
    if (glog.size() == 6 && rlog.size() == 6 && alog.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("alt_grant", glog[k], k % 2);
        chk("alt_rsp_cycle", rlog[k] - alog[0], k + 2);
      end
    end

    // Masked write, then an all-zero-mask write that must change nothing.
    dq0.push_back(mk(1'b1, 9'h010, 8'h55, 8'hFF, 1'b0));
    dq0.push_back(mk(1'b1, 9'h010, 8'hAB, 8'h0F, 1'b0));
    dq0.push_back(mk(1'b0, 9'h010, 8'h00, 8'h00, 1'b0));
    wait_idle("masked_write");
    chk("mask_q", lastq[0], 8'h5B);
    dq1.push_back(mk(1'b1, 9'h010, 8'hFF, 8'h00, 1'b0));
    dq1.push_back(mk(1'b0, 9'h010, 8'h00, 8'h00, 1'b0));
    wait_idle("zero_mask_write");
    chk("zero_mask_q", lastq[1], 8'h5B);

    // Random traffic on a small address window to provoke hazards.
    for (int k = 0; k < 200; k++) begin
      dq0.push_back(mk(1'($urandom), 9'($urandom_range(0, 15)), 8'($urandom),
                       ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), $urandom_range(0, 2) == 0));
      dq1.push_back(mk(1'($urandom), 9'($urandom_range(0, 15)), 8'($urandom),
                       ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), $urandom_range(0, 2) == 0));
    end
    wait_idle("random_traffic");

    // Reset pulse in the middle of the clear sweep.
    @(posedge CLK); #2 rstn = 1'b0;
    repeat (2) @(posedge CLK);
    #2 rstn = 1'b1;
    repeat (201) @(posedge CLK);
    #2;
    chk("mid_clear_a", sram_a, 9'd200);
    chk("mid_clear_cen", sram_cen, 1'b0);
    rstn = 1'b0;
    repeat (2) @(posedge CLK);
    #2 rstn = 1'b1;
    dq0.push_back(mk(1'b0, 9'h1A5, 8'h00, 8'h00, 1'b0));
    wait_idle("restart_clear");
    chk("recleared_q", lastq[0], 8'h00);
    chk("recleared_done", clear_done, 1'b1);

    // Instance without clear: in service straight out of reset.
    @(posedge CLK); #1;
    b_valid = 1'b1; b_we = 1'b0; b_a = 9'h033;
    @(negedge CLK);
    chk("b_rst_ready", b_ready0, 1'b0);
    chk("b_rst_done", b_done, 1'b0);
    chk("b_rst_cen", b_cen, 1'b1);
    @(posedge CLK); #2 b_rstn = 1'b1;
    #1;
    chk("b_done", b_done, 1'b1);
    chk("b_ready0", b_ready0, 1'b1);
    chk("b_ready1", b_ready1, 1'b0);
    @(posedge CLK); #1 b_valid = 1'b0;
    chk("b_cen", b_cen, 1'b0);
    chk("b_gwen", b_gwen, 1'b1);
    chk("b_wen", b_wen, 8'hFF);
    chk("b_a", b_sa, 9'h033);
    chk("b_d", b_d, 8'h00);
    chk("b_early_rsp", b_rsp0_valid, 1'b0);
    @(posedge CLK); #1;
    chk("b_rsp_valid", b_rsp0_valid, 1'b1);
    chk("b_rsp_q", b_rsp0_q, 8'h69);
    chk("b_rsp1_valid", b_rsp1_valid, 1'b0);
    chk("b_rsp1_q", b_rsp1_q, 8'h69);
    chk("b_idle_cen", b_cen, 1'b1);
    @(posedge CLK); #1;
    chk("b_rsp_gone", b_rsp0_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
